// File: rtl/spi_ctrl_master.sv
// spi_ctrl_master: byte-oriented SPI mode-0 controller with valid/ready TX input
// and a one-cycle RX strobe. Chip select stays low across a frame until the
// host flags the last byte.
// Optional feature: define SPI_CTRL_LOOPBACK_EN to add loopback_i, which feeds
// the outgoing data line back into the receive shifter.
module spi_ctrl_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_last_i,
  output logic       tx_ready_o,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       busy_o,
  output logic       spi_clock_o,
  output logic       spi_cs_o,
  output logic       spi_pico_o,
`ifdef SPI_CTRL_LOOPBACK_EN
  input  logic       loopback_i,
`endif
  input  logic       spi_poci_i
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic        sck_q, sck_d;
  logic        cs_q, cs_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        last_q, last_d;
  logic [7:0]  txShift_q, txShift_d;
  logic [7:0]  rxShift_q, rxShift_d;
  logic [7:0]  rxData_q, rxData_d;
  logic        rxValid_q, rxValid_d;
  logic        handshake;
  logic        cntDone;
  logic        sampleBit;

  assign handshake = tx_valid_i & ready_q;
  assign cntDone   = (cnt_q == 8'd0);

`ifdef SPI_CTRL_LOOPBACK_EN
  assign sampleBit = loopback_i ? txShift_q[7] : spi_poci_i;
`else
  assign sampleBit = spi_poci_i;
`endif

  // Registers for state and every output; reset discards any partial byte.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      bitIdx_q  <= 3'd0;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
      txShift_q <= 8'h00;
      rxShift_q <= 8'h00;
      rxData_q  <= 8'h00;
      rxValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitIdx_q  <= bitIdx_d;
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      txShift_q <= txShift_d;
      rxShift_q <= rxShift_d;
      rxData_q  <= rxData_d;
      rxValid_q <= rxValid_d;
    end
  end

  // Next-state logic: each phase lasts CLK_DIV cycles, SCK edges fall on
  // phase boundaries; pin levels are decoded from the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitIdx_d  = bitIdx_q;
    sck_d     = sck_q;
    last_d    = last_q;
    txShift_d = txShift_q;
    rxShift_d = rxShift_q;
    rxData_d  = rxData_q;
    rxValid_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (handshake) begin
          txShift_d = tx_data_i;
          last_d    = tx_last_i;
          cnt_d     = RELOAD;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cntDone) begin
          sck_d     = 1'b1;
          rxShift_d = {rxShift_q[6:0], sampleBit};
          bitIdx_d  = 3'd0;
          cnt_d     = RELOAD;
          state_d   = ST_SHIFT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SHIFT: begin
        if (cntDone) begin
          cnt_d = RELOAD;
          if (sck_q) begin
            sck_d = 1'b0;
            if (bitIdx_q == 3'd7) begin
              rxData_d  = rxShift_q;
              rxValid_d = 1'b1;
              state_d   = last_q ? ST_HOLD : ST_WAIT;
            end else begin
              txShift_d = {txShift_q[6:0], 1'b0};
              bitIdx_d  = bitIdx_q + 3'd1;
            end
          end else begin
            sck_d     = 1'b1;
            rxShift_d = {rxShift_q[6:0], sampleBit};
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cntDone) begin
          cnt_d   = RELOAD;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (cntDone) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sck_d   = 1'b0;
      end
    endcase

    cs_d    = !(state_d == ST_SETUP || state_d == ST_SHIFT ||
                state_d == ST_WAIT  || state_d == ST_HOLD);
    ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT);
    busy_d  = (state_d != ST_IDLE);
  end

  assign tx_ready_o  = ready_q;
  assign rx_valid_o  = rxValid_q;
  assign rx_data_o   = rxData_q;
  assign busy_o      = busy_q;
  assign spi_clock_o = sck_q;
  assign spi_cs_o    = cs_q;
  assign spi_pico_o  = txShift_q[7];

endmodule

// File: tb/tb_spi_ctrl_master.sv
// tb_spi_ctrl_master: directed checks of spi_ctrl_master with a small SPI
// peripheral model; a CLK_DIV=4 instance plus a CLK_DIV=1 instance.
module tb_spi_ctrl_master;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] txData = 8'h00;
  logic       txLast = 1'b0;

  logic       txValid = 1'b0;
  logic       txReady, rxValid, busy, sck, cs, pico, poci;
  logic [7:0] rxData;
  logic       loopback = 1'b0;

  logic       fastValid = 1'b0;
  logic       fastReady, fastRxValid, fastBusy, fastSck, fastCs, fastPico;
  logic [7:0] fastRxData;
  logic       fastLoopback = 1'b0;

  int checkCount = 0;
  int failCount  = 0;

  // Peripheral model and event counters
  logic [7:0] periphByte = 8'h00;
  logic [7:0] pShift = 8'h00;
  logic [2:0] pCnt = 3'd0;
  logic [7:0] pRx = 8'h00;
  logic       sckPrev = 1'b0;
  logic       csPrev = 1'b1;
  logic       monClear = 1'b0;
  int         riseCount = 0;
  int         strobeCount = 0;
  int         csRiseCount = 0;

  always #5 clock = ~clock;

  assign poci = pShift[7];

  spi_ctrl_master #(.CLK_DIV(4)) dut (
    .wb_clk_i   (clock),
    .wb_rst_i   (reset),
    .tx_valid_i (txValid),
    .tx_data_i  (txData),
    .tx_last_i  (txLast),
    .tx_ready_o (txReady),
    .rx_valid_o (rxValid),
    .rx_data_o  (rxData),
    .busy_o     (busy),
    .spi_clock_o(sck),
    .spi_cs_o   (cs),
    .spi_pico_o (pico),
`ifdef SPI_CTRL_LOOPBACK_EN
    .loopback_i (loopback),
`endif
    .spi_poci_i (poci)
  );

  spi_ctrl_master #(.CLK_DIV(1)) dutFast (
    .wb_clk_i   (clock),
    .wb_rst_i   (reset),
    .tx_valid_i (fastValid),
    .tx_data_i  (txData),
    .tx_last_i  (txLast),
    .tx_ready_o (fastReady),
    .rx_valid_o (fastRxValid),
    .rx_data_o  (fastRxData),
    .busy_o     (fastBusy),
    .spi_clock_o(fastSck),
    .spi_cs_o   (fastCs),
    .spi_pico_o (fastPico),
`ifdef SPI_CTRL_LOOPBACK_EN
    .loopback_i (fastLoopback),
`endif
    .spi_poci_i (1'b1)
  );

  // Mode-0 peripheral: shifts out on SCK falls, captures pico on rises,
  // reloads its reply byte while cs is high or after every 8 bits.
  always @(posedge clock) begin
    if (cs) begin
      pShift <= periphByte;
      pCnt   <= 3'd0;
    end else if (!sck && sckPrev) begin
      if (pCnt == 3'd7) begin
        pShift <= periphByte;
        pCnt   <= 3'd0;
      end else begin
        pShift <= {pShift[6:0], 1'b0};
        pCnt   <= pCnt + 3'd1;
      end
    end
    if (sck && !sckPrev) pRx <= {pRx[6:0], pico};
    if (monClear) begin
      riseCount   <= 0;
      strobeCount <= 0;
      csRiseCount <= 0;
    end else begin
      if (sck && !sckPrev) riseCount <= riseCount + 1;
      if (rxValid) strobeCount <= strobeCount + 1;
      if (cs && !csPrev) csRiseCount <= csRiseCount + 1;
    end
    sckPrev <= sck;
    csPrev  <= cs;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clearMonitor();
    monClear = 1'b1;
    stepCycle();
    monClear = 1'b0;
  endtask

  // Offers one byte to the CLK_DIV=4 instance; returns one cycle after the handshake edge.
  task automatic applyStimulus(input logic [7:0] data, input logic last);
    int guard = 0;
    while (!txReady && guard < 300) begin
      stepCycle();
      guard++;
    end
    if (!txReady) checkOutput("ready_timeout", 32'(txReady), 32'd1);
    txData  = data;
    txLast  = last;
    txValid = 1'b1;
    stepCycle();
    txValid = 1'b0;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while (busy && guard < 400) begin
      stepCycle();
      guard++;
    end
    if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
    stepCycle();
    stepCycle();
  endtask

  initial begin
    int n;
    int guard;
    int rises;
    int rxAt;
    logic prev;
    logic sckAt2;
    logic sckAt3;
    logic [7:0] frame [3];
    frame[0] = 8'h01;
    frame[1] = 8'h02;
    frame[2] = 8'h03;

    // Reset values
    reset = 1'b1;
    stepCycle();
    stepCycle();
    stepCycle();
    checkOutput("rst_ready", 32'(txReady), 32'd0);
    checkOutput("rst_rx_valid", 32'(rxValid), 32'd0);
    checkOutput("rst_rx_data", 32'(rxData), 32'h00);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_sck", 32'(sck), 32'd0);
    checkOutput("rst_cs", 32'(cs), 32'd1);
    checkOutput("rst_pico", 32'(pico), 32'd0);
    reset = 1'b0;
    stepCycle();
    checkOutput("post_rst_ready", 32'(txReady), 32'd1);

    // Single byte A5, peripheral replies 3C
    periphByte = 8'h3C;
    clearMonitor();
    applyStimulus(8'hA5, 1'b1);
    n = 1;
    checkOutput("single_cs_low", 32'(cs), 32'd0);
    checkOutput("single_pico_b7", 32'(pico), 32'd1);
    checkOutput("single_ready_low", 32'(txReady), 32'd0);
    while (!rxValid && n < 200) begin stepCycle(); n++; end
    checkOutput("single_rx_cycle", 32'(n), 32'd65);
    checkOutput("single_rx_data", 32'(rxData), 32'h3C);
    stepCycle(); n++;
    checkOutput("single_rx_pulse", 32'(rxValid), 32'd0);
    while (!cs && n < 300) begin stepCycle(); n++; end
    checkOutput("single_cs_rise", 32'(n), 32'd69);
    while (!txReady && n < 300) begin stepCycle(); n++; end
    checkOutput("single_ready_back", 32'(n), 32'd73);
    checkOutput("single_pico_pattern", 32'(pRx), 32'hA5);
    checkOutput("single_rises", 32'(riseCount), 32'd8);
    checkOutput("single_rx_hold", 32'(rxData), 32'h3C);

    // Multi-byte frame with tx_valid held high
    periphByte = 8'h5A;
    clearMonitor();
    txValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      txData = frame[i];
      txLast = (i == 2);
      guard = 0;
      while (!txReady && guard < 300) begin stepCycle(); guard++; end
      if (!txReady) checkOutput("multi_ready_timeout", 32'(txReady), 32'd1);
      stepCycle();
    end
    txValid = 1'b0;
    waitIdle();
    checkOutput("multi_strobes", 32'(strobeCount), 32'd3);
    checkOutput("multi_cs_rises", 32'(csRiseCount), 32'd1);
    checkOutput("multi_rises", 32'(riseCount), 32'd24);
    checkOutput("multi_rx_data", 32'(rxData), 32'h5A);
    checkOutput("multi_last_byte", 32'(pRx), 32'h03);

    // Minimum divider on the CLK_DIV=1 instance
    txData = 8'hFF;
    txLast = 1'b1;
    fastValid = 1'b1;
    stepCycle();
    fastValid = 1'b0;
    n = 1;
    rises = 0;
    rxAt = 0;
    prev = fastSck;
    sckAt2 = 1'b0;
    sckAt3 = 1'b1;
    checkOutput("fast_cs_low", 32'(fastCs), 32'd0);
    while (n < 40) begin
      stepCycle(); n++;
      if (fastSck && !prev) rises++;
      if (fastRxValid) rxAt = n;
      if (n == 2) sckAt2 = fastSck;
      if (n == 3) sckAt3 = fastSck;
      prev = fastSck;
    end
    checkOutput("fast_sck_hi", 32'(sckAt2), 32'd1);
    checkOutput("fast_sck_lo", 32'(sckAt3), 32'd0);
    checkOutput("fast_rises", 32'(rises), 32'd8);
    checkOutput("fast_rx_cycle", 32'(rxAt), 32'd17);
    checkOutput("fast_rx_data", 32'(fastRxData), 32'hFF);

    // Reset after the 4th SCK rise
    periphByte = 8'h3C;
    clearMonitor();
    applyStimulus(8'hC3, 1'b1);
    guard = 0;
    while (riseCount < 4 && guard < 200) begin stepCycle(); guard++; end
    checkOutput("midrst_rises", 32'(riseCount), 32'd4);
    reset = 1'b1;
    stepCycle();
    checkOutput("midrst_cs", 32'(cs), 32'd1);
    checkOutput("midrst_sck", 32'(sck), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_rx_valid", 32'(rxValid), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 80; i++) stepCycle();
    checkOutput("midrst_no_strobe", 32'(strobeCount), 32'd0);
    checkOutput("midrst_rx_data", 32'(rxData), 32'h00);
    applyStimulus(8'hA5, 1'b1);
    waitIdle();
    checkOutput("midrst_after_strobe", 32'(strobeCount), 32'd1);
    checkOutput("midrst_after_data", 32'(rxData), 32'h3C);

`ifdef SPI_CTRL_LOOPBACK_EN
    // Loopback: the received byte mirrors the transmitted one
    periphByte = 8'h00;
    loopback = 1'b1;
    clearMonitor();
    applyStimulus(8'h96, 1'b1);
    waitIdle();
    checkOutput("loop_rx_data", 32'(rxData), 32'h96);
    loopback = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/spi_ctrl_master.md
# spi_ctrl_master

SPI controller (initiator) that drives a byte-oriented SPI peripheral, such as the `titan` SPI target, from the user-project clock domain. It accepts bytes on a valid/ready interface and shifts them out MSB-first in SPI mode 0 (CPOL=0, CPHA=0). It returns each received byte on a one-cycle strobe. Chip select is held low across multi-byte frames until the host marks the last byte.

## Interface
- `CLK_DIV`, default 4: SCK half-period in `wb_clk_i` cycles. Legal range is 1..255; SCK period is 2·CLK_DIV cycles.
- `wb_clk_i`  in  1  system clock. Every output and every state change is registered on its rising edge.
- `wb_rst_i`  in  1  reset. One clock; reset is synchronous and active-high.
- `tx_valid_i`  in  1  host offers a byte.
- `tx_data_i`  in  8  byte to transmit.
- `tx_last_i`  in  1  qualifies the offered byte as the final byte of the frame.
- `tx_ready_o`  out  1  controller can accept a byte.
- `rx_valid_o`  out  1  one-cycle strobe: `rx_data_o` holds a new byte.
- `rx_data_o`  out  8  last received byte. Holds its value between strobes.
- `busy_o`  out  1  high in any state other than IDLE.
- `spi_clock_o`  out  1  SCK. Idles low.
- `spi_cs_o`  out  1  chip select, active low.
- `spi_pico_o`  out  1  controller-out / peripheral-in data line.
- `spi_poci_i`  in  1  peripheral-out / controller-in data line.

## Operation
- States: IDLE, SETUP, SHIFT, WAIT, HOLD, GAP.
- **IDLE**
  - Outputs: cs=1, sck=0, `tx_ready_o`=1.
  - A handshake (`tx_valid_i` & `tx_ready_o`) latches `tx_data_i` and `tx_last_i` and moves to SETUP.
- **SETUP**
  - Outputs: cs=0, sck=0, pico = bit 7.
  - Lasts CLK_DIV cycles, then moves to SHIFT.
- **SHIFT**
  - 8 bits, MSB first.
  - On each SCK rising edge, `spi_poci_i` is sampled into the RX shift register.
  - On each falling edge, pico advances to the next bit.
  - After the 8th falling edge:
    - `rx_data_o` is loaded and `rx_valid_o` pulses for 1 cycle.
    - If last is latched, go to HOLD; otherwise go to WAIT.
- **WAIT**
  - Outputs: cs=0, sck=0, pico holds bit 0, `tx_ready_o`=1.
  - A handshake latches the new byte and last flag and moves to SETUP; cs stays low.
  - The controller stays in WAIT indefinitely with no timeout.
- **HOLD**
  - Outputs: cs=0, sck=0.
  - Lasts CLK_DIV cycles. cs then rises on the transition into GAP.
- **GAP**
  - Outputs: cs=1, sck=0.
  - Lasts CLK_DIV cycles and guarantees the minimum CS-high time; then moves to IDLE.
- `tx_ready_o` is 0 in SETUP, SHIFT, HOLD and GAP. `tx_data_i` is don't-care outside a handshake.
- Reset values:
  - `tx_ready_o`=0 while `wb_rst_i`=1; it rises in the first cycle after reset deasserts.
  - `rx_valid_o`=0, `rx_data_o`=8'h00, `busy_o`=0, `spi_clock_o`=0, `spi_cs_o`=1, `spi_pico_o`=0.
- Reset mid-frame:
  - The next edge forces reset values and IDLE.
  - The partial byte is discarded and no `rx_valid_o` is issued.
  - cs rises without a HOLD or GAP phase.
- `rx_valid_o` and a new handshake in WAIT may occur in the same cycle. Both are honoured; `rx_data_o` still reflects the previous byte.

## Timing
- Handshake at edge k from IDLE or WAIT:
  - k+1: cs low (or remains low), pico = bit 7.
  - k+1+CLK_DIV: first SCK rise.
  - k+1+(2n+1)·CLK_DIV: SCK rise for bit 7−n, n = 0..7.
  - k+1+(2n+2)·CLK_DIV: SCK fall for bit 7−n.
  - k+1+16·CLK_DIV: `rx_valid_o` high.
- Last byte: cs rises CLK_DIV cycles after the final SCK fall. `tx_ready_o` returns after a further CLK_DIV cycles.
- Byte-to-byte throughput in a frame: 16·CLK_DIV + 1 cycles per byte plus the host's WAIT latency. The minimum is 1 cycle when `tx_valid_i` is held high.
- The half-period counter is 8 bits and reloads to CLK_DIV−1 at each phase boundary. Behaviour with CLK_DIV=0 is undefined.

## Configuration
- `SPI_CTRL_LOOPBACK_EN`
  - **Defined:** adds input port `loopback_i` (1 bit). When it is high, the RX shift register samples the registered `spi_poci_o`... more precisely, it samples `spi_pico_o` instead of `spi_poci_i` on each SCK rise, and `spi_poci_i` is ignored. The pins continue to toggle normally.
  - **Not defined:** `loopback_i` does not exist and `spi_poci_i` is always sampled.

## Test plan
- **Reset values:** hold reset 3 cycles, then release → all outputs at their reset values during reset; `tx_ready_o`=1 on the first post-reset cycle.
- **Single byte:** CLK_DIV=4, send 8'hA5 with last=1, peripheral model returns 8'h3C → pico pattern 1,0,1,0,0,1,0,1 on rises; `rx_valid_o` with 8'h3C at k+65; cs high at k+69; `tx_ready_o` at k+73.
- **Multi-byte frame:** send 8'h01 (last=0), 8'h02 (last=0), 8'h03 (last=1), with `tx_valid_i` held high → cs stays low for all 24 bits; 3 `rx_valid_o` strobes; exactly one cs rise.
- **Minimum divider:** CLK_DIV=1, send 8'hFF → SCK period is 2 cycles; 8 rises seen; `rx_valid_o` at k+17.
- **Reset mid-frame:** assert reset after the 4th SCK rise → next edge gives cs=1, sck=0; no `rx_valid_o`; a new byte is accepted normally afterwards.
- **Loopback (with `SPI_CTRL_LOOPBACK_EN`):** `loopback_i`=1, send 8'h96, drive `spi_poci_i` to constant 0 → `rx_data_o`=8'h96.
